// File: rtl/host_watchdog_pkg.sv
// Shared constants for the host write watchdog: register address, widths,
// state encoding and status-word bit positions.
package host_watchdog_pkg;

    localparam logic [7:0] ADDR_WDOG_DEFAULT = 8'h03;
    localparam int         PRESC_W_DEFAULT   = 8;
    localparam int         PERIOD_W_DEFAULT  = 16;

    localparam logic [1:0] WDOG_DISABLED = 2'b00;
    localparam logic [1:0] WDOG_ARMED    = 2'b01;
    localparam logic [1:0] WDOG_EXPIRED  = 2'b10;

    localparam int TIMEOUT_BIT = 31;
    localparam int STATE_MSB   = 30;
    localparam int STATE_LSB   = 29;

endpackage

// File: rtl/wdog_prescaler.sv
// Free-running prescaler for the host watchdog: one-cycle tick each time the
// counter sits at all-ones while enabled; clear has priority over enable.
module wdog_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic sysclk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [PRESC_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

    assign tick = en && (&cnt);

endmodule

// File: rtl/host_watchdog.sv
// Host write watchdog: sticky timeout when no register write arrives within the
// programmed period. Define HOST_WATCHDOG_CNT_READ_EN to expose the live tick count at ADDR_WDOG+1.
module host_watchdog
    import host_watchdog_pkg::*;
#(
    parameter logic [7:0] ADDR_WDOG = ADDR_WDOG_DEFAULT,
    parameter int         PRESC_W   = PRESC_W_DEFAULT,
    parameter int         PERIOD_W  = PERIOD_W_DEFAULT
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic        blk_wen,
    output logic        wdog_timeout,
    output logic [1:0]  wdog_state,
    output logic [31:0] wdog_rdata
);

    logic [1:0]          state;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] count_inc;
    logic                cfg_wr;
    logic                activity;
    logic                armed;
    logic                tick;
    logic                unused_wdata;

    assign cfg_wr       = reg_wen && (reg_addr == ADDR_WDOG);
    assign activity     = reg_wen || blk_wen;
    assign armed        = (state == WDOG_ARMED);
    assign count_inc    = count + PERIOD_W'(1);
    assign unused_wdata = ^reg_wdata[31:PERIOD_W];

    // Frozen outside ARMED, so an expired watchdog keeps its elapsed-tick snapshot.
    wdog_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .sysclk (sysclk),
        .reset  (reset),
        .en     (armed),
        .clr    (cfg_wr || (armed && activity)),
        .tick   (tick)
    );

    // Priority: config write, then host activity, then the counting tick.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state        <= WDOG_DISABLED;
            period       <= '0;
            count        <= '0;
            wdog_timeout <= 1'b0;
        end else if (cfg_wr) begin
            period       <= reg_wdata[PERIOD_W-1:0];
            count        <= '0;
            wdog_timeout <= 1'b0;
            state        <= (reg_wdata[PERIOD_W-1:0] != '0) ? WDOG_ARMED : WDOG_DISABLED;
        end else if (armed) begin
            if (activity) begin
                count <= '0;
            end else if (tick) begin
                count <= count_inc;
                if (count_inc == period) begin
                    state        <= WDOG_EXPIRED;
                    wdog_timeout <= 1'b1;
                end
            end
        end
    end

    assign wdog_state = state;

    // NOTE: default every combinational output first so no path can infer a latch.
    always_comb begin
        wdog_rdata = '0;
        if (reg_addr == ADDR_WDOG) begin
            wdog_rdata[TIMEOUT_BIT]         = wdog_timeout;
            wdog_rdata[STATE_MSB:STATE_LSB] = state;
            wdog_rdata[PERIOD_W-1:0]        = period;
        end
`ifdef HOST_WATCHDOG_CNT_READ_EN
        else if (reg_addr == ADDR_WDOG + 8'd1) begin
            wdog_rdata[PERIOD_W-1:0] = count;
        end
`endif
    end

endmodule

// File: tb/tb_host_watchdog.sv
// Directed self-checking bench for host_watchdog; expected timings are derived
// from the tick period of 256 sysclk cycles.
module tb_host_watchdog;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] reg_wdata = 32'h0;
    logic        reg_wen = 1'b0;
    logic        blk_wen = 1'b0;
    logic        wdog_timeout;
    logic [1:0]  wdog_state;
    logic [31:0] wdog_rdata;

    int total = 0;
    int bad = 0;

    host_watchdog dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wen      (reg_wen),
        .blk_wen      (blk_wen),
        .wdog_timeout (wdog_timeout),
        .wdog_state   (wdog_state),
        .wdog_rdata   (wdog_rdata)
    );

    always #5 sysclk = ~sysclk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // One-cycle write; returns 1 ns after the edge that samples it.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wen   = 1'b1;
        step(1);
        reg_wen   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        reg_addr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step(3);
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL rst_state: got %b want 00", wdog_state); end
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", wdog_timeout); end
        reset = 1'b1;
        step(10000);
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL idle_state: got %b want 00", wdog_state); end
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL idle_timeout: got %b want 0", wdog_timeout); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata: got %h want 00000000", wdog_rdata); end
    endtask

    task automatic test_expiry;
        wr(8'h03, 32'h0000_0004);
        total++; if (wdog_state !== 2'b01) begin bad++; $display("FAIL arm_state: got %b want 01", wdog_state); end
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL arm_timeout: got %b want 0", wdog_timeout); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'h2000_0004) begin bad++; $display("FAIL arm_rdata: got %h want 20000004", wdog_rdata); end
        rd(8'h05);
        total++; if (wdog_rdata !== 32'h0) begin bad++; $display("FAIL other_addr: got %h want 00000000", wdog_rdata); end
        step(1023);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL exp_early: got %b want 0", wdog_timeout); end
        step(1);
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL exp_edge: got %b want 1", wdog_timeout); end
        total++; if (wdog_state !== 2'b10) begin bad++; $display("FAIL exp_state: got %b want 10", wdog_state); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'hC000_0004) begin bad++; $display("FAIL exp_rdata: got %h want c0000004", wdog_rdata); end
    endtask

    task automatic test_keepalive;
        logic seen;
        seen = 1'b0;
        wr(8'h03, 32'h0000_0004);
        repeat (22) begin
            for (int i = 0; i < 899; i++) begin
                step(1);
                if (wdog_timeout) seen = 1'b1;
            end
            wr(8'h10, 32'hFFFF_FFFF);
            if (wdog_timeout) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ka_never: got %b want 0", seen); end
        total++; if (wdog_state !== 2'b01) begin bad++; $display("FAIL ka_state: got %b want 01", wdog_state); end
        step(1023);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL ka_early: got %b want 0", wdog_timeout); end
        step(1);
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL ka_edge: got %b want 1", wdog_timeout); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'hC000_0004) begin bad++; $display("FAIL ka_rdata: got %h want c0000004", wdog_rdata); end
    endtask

    task automatic test_blk_coincident;
        wr(8'h03, 32'h0000_0002);
        step(511);
        blk_wen = 1'b1;
        step(1);
        blk_wen = 1'b0;
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL blk_timeout: got %b want 0", wdog_timeout); end
        total++; if (wdog_state !== 2'b01) begin bad++; $display("FAIL blk_state: got %b want 01", wdog_state); end
        step(511);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL blk_early: got %b want 0", wdog_timeout); end
        step(1);
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL blk_edge: got %b want 1", wdog_timeout); end
        total++; if (wdog_state !== 2'b10) begin bad++; $display("FAIL blk_exp_state: got %b want 10", wdog_state); end
    endtask

    task automatic test_cfg_coincident;
        wr(8'h03, 32'h0000_0001);
        step(255);
        wr(8'h03, 32'h0000_0001);
        total++; if (wdog_state !== 2'b01) begin bad++; $display("FAIL cfgco_state: got %b want 01", wdog_state); end
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL cfgco_timeout: got %b want 0", wdog_timeout); end
        step(255);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL cfgco_early: got %b want 0", wdog_timeout); end
        step(1);
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL cfgco_edge: got %b want 1", wdog_timeout); end
    endtask

    task automatic test_expired_exit;
        logic [31:0] exp_cnt;
`ifdef HOST_WATCHDOG_CNT_READ_EN
        exp_cnt = 32'h0000_0001;
`else
        exp_cnt = 32'h0000_0000;
`endif
        wr(8'h10, 32'h0000_0000);
        step(300);
        total++; if (wdog_state !== 2'b10) begin bad++; $display("FAIL frz_state: got %b want 10", wdog_state); end
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL frz_timeout: got %b want 1", wdog_timeout); end
        rd(8'h04);
        total++; if (wdog_rdata !== exp_cnt) begin bad++; $display("FAIL frz_count: got %h want %h", wdog_rdata, exp_cnt); end
        wr(8'h03, 32'h0000_0000);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL dis_timeout: got %b want 0", wdog_timeout); end
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL dis_state: got %b want 00", wdog_state); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'h0) begin bad++; $display("FAIL dis_rdata: got %h want 00000000", wdog_rdata); end
        step(600);
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL dis_hold: got %b want 00", wdog_state); end
        wr(8'h03, 32'h0000_0001);
        total++; if (wdog_state !== 2'b01) begin bad++; $display("FAIL rearm_state: got %b want 01", wdog_state); end
        step(255);
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL rearm_early: got %b want 0", wdog_timeout); end
        step(1);
        total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL rearm_edge: got %b want 1", wdog_timeout); end
        total++; if (wdog_state !== 2'b10) begin bad++; $display("FAIL rearm_exp: got %b want 10", wdog_state); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp_cnt;
`ifdef HOST_WATCHDOG_CNT_READ_EN
        exp_cnt = 32'h0000_0003;
`else
        exp_cnt = 32'h0000_0000;
`endif
        reset = 1'b0;
        #1;
        total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL rstexp_timeout: got %b want 0", wdog_timeout); end
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL rstexp_state: got %b want 00", wdog_state); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'h0) begin bad++; $display("FAIL rstexp_rdata: got %h want 00000000", wdog_rdata); end
        step(2);
        reset = 1'b1;
        wr(8'h03, 32'h0000_0008);
        step(3 * 256 + 10);
        rd(8'h04);
        total++; if (wdog_rdata !== exp_cnt) begin bad++; $display("FAIL mid_count: got %h want %h", wdog_rdata, exp_cnt); end
        rd(8'h03);
        total++; if (wdog_rdata !== 32'h2000_0008) begin bad++; $display("FAIL mid_rdata: got %h want 20000008", wdog_rdata); end
        reset = 1'b0;
        #1;
        total++; if (wdog_state !== 2'b00) begin bad++; $display("FAIL rstmid_state: got %b want 00", wdog_state); end
        total++; if (wdog_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 00000000", wdog_rdata); end
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_keepalive();
        test_blk_coincident();
        test_cfg_coincident();
        test_expired_exit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_watchdog.md
Name: host_watchdog

Overview:
- Sits between the phy-link register bus (reg_wen/blk_wen/reg_addr/reg_wdata) and board register logic.
- Monitors host write activity and asserts a sticky timeout when no write arrives within a host-programmed period.
- wdog_timeout is ORed into the per-axis amp-disable path, alongside safety_amp_disable.
- Status is read back through the channel-0 read mux.

Parameters:
- ADDR_WDOG, 8'h03, register address for period write/status read.
- PRESC_W, 8, prescaler width; one tick every 2^PRESC_W sysclk cycles (256 cycles ≈ 5.2 µs at 49.152 MHz).
- PERIOD_W, 16, width of period and tick counter.

Ports:
- sysclk  in  1  system clock, 49.152 MHz.
- reset  in  1  asynchronous, active-low reset.
- reg_addr  in  8  register address from phy-link.
- reg_wdata  in  32  register write data.
- reg_wen  in  1  single-cycle quadlet write strobe.
- blk_wen  in  1  single-cycle end-of-block-write strobe.
- wdog_timeout  out  1  sticky timeout flag, to amp-disable logic.
- wdog_state  out  2  00 DISABLED, 01 ARMED, 10 EXPIRED.
- wdog_rdata  out  32  status word, combinational on reg_addr.

Behaviour:
- Reset (reset low, async):
  - state=DISABLED, period=0, count=0, prescaler=0.
  - wdog_timeout=0, wdog_state=00, all registered bits of wdog_rdata zero.
- Config write: reg_wen=1 and reg_addr==ADDR_WDOG in cycle N.
  - At N+1: period<=reg_wdata[PERIOD_W-1:0], count=0, prescaler=0, wdog_timeout=0.
  - period!=0: state ARMED. period==0: state DISABLED.
  - Accepted in every state; this is the only way to leave EXPIRED.
- Activity: any reg_wen or blk_wen at any address, including ADDR_WDOG.
  - In ARMED: clears count and prescaler the next cycle.
  - In DISABLED/EXPIRED: ignored.
- Prescaler:
  - Free-runs only in ARMED.
  - tick=1 for one cycle when prescaler==all-ones, then it wraps to 0.
- Counter:
  - Increments on tick in ARMED.
  - If a tick makes count==period: state<=EXPIRED and wdog_timeout<=1 on the same edge.
  - From a config write in cycle N with no further activity, wdog_timeout rises at edge N+1+period*2^PRESC_W.
- Simultaneous events:
  - Activity coincident with the terminal tick: activity wins, no expiry, count cleared.
  - Config write coincident with the terminal tick: the config write wins.
- EXPIRED:
  - count and prescaler frozen; wdog_timeout held at 1 until a config write.
- wdog_rdata:
  - reg_addr==ADDR_WDOG: {wdog_timeout, wdog_state[1:0], 13'b0, period[15:0]}.
  - Otherwise 0.
- wdog_state mirrors the state register, with no extra latency.
- Reset asserted mid-operation (including in EXPIRED): everything returns to reset values immediately; wdog_timeout drops asynchronously.
- Widths: count is never compared beyond PERIOD_W bits and cannot wrap, because expiry stops it at period ≤ 2^PERIOD_W-1.

Optional Feature:
- Macro: HOST_WATCHDOG_CNT_READ_EN.
- Defined: reads at reg_addr==ADDR_WDOG+1 return {16'b0, count[15:0]}, showing live elapsed ticks.
- Undefined: that address returns 0, and count has no read path.

Decomposition:
- Shared package:
  - ADDR_WDOG default
  - state encoding constants (WDOG_DISABLED=2'b00, WDOG_ARMED=2'b01, WDOG_EXPIRED=2'b10)
  - status-word bit positions (TIMEOUT_BIT=31, STATE_MSB=30, STATE_LSB=29)
- One natural sub-module: wdog_prescaler.
  - PRESC_W-bit counter with enable and synchronous clear; outputs tick.
- State machine, period register and counter stay in host_watchdog.

Test Plan:
- Reset then idle 10000 cycles -> wdog_state=00, wdog_timeout=0, wdog_rdata at 0x03 == 0x00000000.
- Write 0x00000004 to 0x03 at cycle N, no activity -> wdog_state=01 at N+1; wdog_timeout rises exactly at N+1+1024; rdata == 0xC0000004.
- Period=4; reg_wen to address 0x10 every 900 cycles for 20000 cycles -> wdog_timeout never asserts; then stop writes -> timeout 1024 cycles after last write +1.
- Period=2, blk_wen pulse aligned with terminal tick (cycle N+1+512) -> no expiry; timeout occurs at 512 cycles after the pulse instead.
- While EXPIRED, write 0x00000000 to 0x03 -> next cycle wdog_timeout=0, wdog_state=00; then write 0x00000001 -> ARMED, expiry 256 cycles later.
- Period=8 ARMED, drop reset mid-count -> wdog_timeout/state/period immediately 0; with HOST_WATCHDOG_CNT_READ_EN, read 0x04 mid-count after 3*256+10 cycles -> 0x00000003.
